// File: rtl/dma_fifo_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : dma_fifo_reader_if
// Description : One DMA sequencer request slot (req/ack/end/rnw/addr/wd/rd).
//               The client drives the request side, the sequencer answers.
// Revision    : 1.0 - initial release
// ============================================================================
interface dma_fifo_reader_if;
  logic        dma_req;
  logic [20:0] dma_addr;
  logic        dma_rnw;
  logic [7:0]  dma_wd;
  logic        dma_ack;
  logic        dma_end;
  logic [7:0]  dma_rd;

  // Client side of the slot
  modport master (
    output dma_req, dma_addr, dma_rnw, dma_wd,
    input  dma_ack, dma_end, dma_rd
  );

  // Sequencer side of the slot
  modport slave (
    input  dma_req, dma_addr, dma_rnw, dma_wd,
    output dma_ack, dma_end, dma_rd
  );
endinterface
`default_nettype wire

// File: rtl/dma_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module      : dma_fifo_reader
// Description : Read-only DMA client. Streams bytes from a sequential (optionally
//               looping) address range into a small first-word-fall-through
//               FIFO. In-flight reads are counted so the FIFO never overflows,
//               and reads still in flight across an init are discarded.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_fifo_reader #(
  parameter int DEPTH_LOG = 3
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        init,
  input  wire logic        ena,
  input  wire logic        loop,
  input  wire logic [20:0] start_addr,
  input  wire logic [20:0] end_addr,
  dma_fifo_reader_if.master dma,
  input  wire logic        rd_pop,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             done
);

  localparam int              DEPTH      = 1 << DEPTH_LOG;
  localparam int              CW         = DEPTH_LOG + 1;
  localparam logic [CW-1:0]   CNT_ONE    = 1;
  localparam logic [CW:0]     FULL_LEVEL = DEPTH[CW:0];
  localparam logic [DEPTH_LOG-1:0] PTR_ONE = 1;

  logic [7:0]           mem [DEPTH];
  logic [DEPTH_LOG-1:0] wptr;
  logic [DEPTH_LOG-1:0] rptr;
  logic [CW-1:0]        count;
  logic [CW-1:0]        pend;
  logic [CW-1:0]        drop;

  logic [CW-1:0]        count_next;
  logic [CW-1:0]        pend_next;
  logic [CW-1:0]        drop_next;
  logic [CW:0]          occupancy_next;
  logic                 done_next;
  logic                 new_ok;
  logic                 ack_now;
  logic                 push;
  logic                 pop;
  logic                 at_end;

  // An ack only means something while a request is actually presented
  assign ack_now = dma.dma_ack & dma.dma_req;
  // Ends landing in the init cycle belong to the flushed stream
  assign push    = dma.dma_end & (drop == '0) & ~init;
  assign pop     = rd_pop & (count != '0);
  assign at_end  = (dma.dma_addr == end_addr);

  assign dma.dma_rnw = 1'b1;
  assign dma.dma_wd  = 8'h00;
  assign rd_valid    = (count != '0);
  assign rd_data     = mem[rptr];

  // Post-edge counter values; request permission is judged on these so that
  // FIFO space is reserved for every read already acknowledged
  always_comb begin
    pend_next = pend;
    if (ack_now && !dma.dma_end) begin
      pend_next = pend + CNT_ONE;
    end else if (!ack_now && dma.dma_end) begin
      pend_next = pend - CNT_ONE;
    end

    count_next = count;
    if (init) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count + CNT_ONE;
    end else if (!push && pop) begin
      count_next = count - CNT_ONE;
    end

    drop_next = drop;
    if (init) begin
      drop_next = pend_next;
    end else if (dma.dma_end && (drop != '0)) begin
      drop_next = drop - CNT_ONE;
    end

    done_next = done;
    if (init) begin
      done_next = 1'b0;
    end else if (ack_now && at_end && !loop) begin
      done_next = 1'b1;
    end

    occupancy_next = {1'b0, count_next} + {1'b0, pend_next};
    new_ok = ena & ~done_next & (drop_next == '0) & (occupancy_next < FULL_LEVEL);
  end

  // Slot request, address sequencing and range completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dma.dma_req  <= 1'b0;
      dma.dma_addr <= '0;
      done         <= 1'b0;
    end else begin
      dma.dma_req <= ~init & (ack_now ? new_ok : (dma.dma_req | new_ok));
      done        <= done_next;
      if (init) begin
        dma.dma_addr <= start_addr;
      end else if (ack_now) begin
        if (at_end) begin
          if (loop) begin
            dma.dma_addr <= start_addr;
          end
        end else begin
          dma.dma_addr <= dma.dma_addr + 21'd1;
        end
      end
    end
  end

  // Occupancy, in-flight and discard counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      pend  <= '0;
      drop  <= '0;
    end else begin
      count <= count_next;
      pend  <= pend_next;
      drop  <= drop_next;
    end
  end

  // FIFO pointers; init restarts both at slot zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (init) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_ONE;
      end
      if (pop) begin
        rptr <= rptr + PTR_ONE;
      end
    end
  end

  // FIFO storage; contents are only observed while count covers them
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= dma.dma_rd;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dma_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_fifo_reader
// Description : Self-checking bench for dma_fifo_reader with a queue-based
//               reference model and a behavioural DMA sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_fifo_reader;

  localparam int DEPTH_LOG = 3;
  localparam int DEPTH     = 8;
  localparam int AMASK     = 32'h1FFFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        init = 1'b0;
  logic        ena = 1'b0;
  logic        loop = 1'b0;
  logic [20:0] start_addr = '0;
  logic [20:0] end_addr = '0;
  logic        rd_pop = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        done;

  dma_fifo_reader_if dif ();

  dma_fifo_reader #(.DEPTH_LOG(DEPTH_LOG)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init       (init),
    .ena        (ena),
    .loop       (loop),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .dma        (dif),
    .rd_pop     (rd_pop),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // stimulus knobs (applied inside cycle so model and DUT see the same values)
  int k_ena = 0, k_loop = 0, k_start = 0, k_end = 0;
  int ack_mode = 0;   // 0 never, 1 whenever requested, 2 one cycle after, 3 random
  int ack_pct = 50, lat_min = 1, lat_max = 1, pop_pct = 0;
  bit force_init = 1'b0;

  // reference model state
  int         m_req = 0, m_addr = 0, m_done = 0, m_pend = 0, m_drop = 0, m_age = 0;
  logic [7:0] m_fifo[$];
  int         q_addr[$];
  int         q_due[$];
  int         last_due = 0;

  int         ack_log[$];
  logic [7:0] pop_log[$];

  function automatic logic [7:0] dat(input int a);
    logic [20:0] v;
    v = a[20:0];
    return v[7:0] ^ v[15:8] ^ 8'hA5;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cycle();
    bit ackv, endv, popv, iv, nreq, new_ok;
    logic [7:0] d;
    int pend_n, due;
    @(negedge clk);
    chk("dma_req", int'(dif.dma_req), m_req);
    chk("dma_addr", int'(dif.dma_addr), m_addr);
    chk("done", int'(done), m_done);
    chk("rd_valid", int'(rd_valid), int'(m_fifo.size() != 0));
    chk("dma_rnw", int'(dif.dma_rnw), 1);
    chk("dma_wd", int'(dif.dma_wd), 0);
    if (m_fifo.size() != 0) chk("rd_data", int'(rd_data), int'(m_fifo[0]));

    iv = force_init;
    force_init = 1'b0;
    ackv = 1'b0;
    if (m_req != 0) begin
      case (ack_mode)
        1: ackv = 1'b1;
        2: ackv = (m_age >= 1);
        3: ackv = ($urandom_range(99) < ack_pct);
        default: ackv = 1'b0;
      endcase
    end
    endv = (q_due.size() != 0) && (q_due[0] <= cyc);
    if (endv) begin
      d = dat(q_addr[0]);
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end else begin
      d = 8'($urandom);
    end
    popv = ($urandom_range(99) < pop_pct);
    if (popv && rd_valid) pop_log.push_back(rd_data);

    init         = iv;
    ena          = (k_ena != 0);
    loop         = (k_loop != 0);
    start_addr   = k_start[20:0];
    end_addr     = k_end[20:0];
    dif.dma_ack  = ackv;
    dif.dma_end  = endv;
    dif.dma_rd   = d;
    rd_pop       = popv;

    if (ackv) begin
      ack_log.push_back(m_addr);
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      q_addr.push_back(m_addr);
      q_due.push_back(due);
    end

    pend_n = m_pend + int'(ackv) - int'(endv);
    if (iv) begin
      m_addr = k_start;
      m_fifo.delete();
      m_done = 0;
      m_drop = pend_n;
      m_req  = 0;
      m_age  = 0;
    end else begin
      if (popv && m_fifo.size() != 0) void'(m_fifo.pop_front());
      if (endv) begin
        if (m_drop > 0) m_drop--;
        else m_fifo.push_back(d);
      end
      if (ackv) begin
        if (m_addr == k_end) begin
          if (k_loop != 0) m_addr = k_start;
          else m_done = 1;
        end else begin
          m_addr = (m_addr + 1) & AMASK;
        end
      end
      new_ok = (k_ena != 0) && (m_done == 0) && (m_drop == 0) &&
               (m_fifo.size() + pend_n < DEPTH);
      nreq = ackv ? new_ok : ((m_req != 0) || new_ok);
      m_age = (nreq && (m_req != 0) && !ackv) ? m_age + 1 : 0;
      m_req = int'(nreq);
    end
    m_pend = pend_n;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic start_range(input int s, input int e, input int lp);
    k_start = s;
    k_end = e;
    k_loop = lp;
    force_init = 1'b1;
    ack_log.delete();
    pop_log.delete();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    init = 1'b0; ena = 1'b0; rd_pop = 1'b0;
    dif.dma_ack = 1'b0; dif.dma_end = 1'b0; dif.dma_rd = 8'h00;
    #1;
    chk("rst_dma_req", int'(dif.dma_req), 0);
    chk("rst_dma_addr", int'(dif.dma_addr), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_dma_rnw", int'(dif.dma_rnw), 1);
    chk("rst_dma_wd", int'(dif.dma_wd), 0);
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    m_req = 0; m_addr = 0; m_done = 0; m_pend = 0; m_drop = 0; m_age = 0;
    m_fifo.delete(); q_addr.delete(); q_due.delete();
    last_due = cyc;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    bit hit;
    do_reset();

    // one-shot range 100..105, ack one cycle after request, end two after ack
    k_ena = 1; ack_mode = 2; lat_min = 2; lat_max = 2; pop_pct = 100;
    start_range(32'h100, 32'h105, 0);
    run(40);
    chk("t1_ack_count", ack_log.size(), 6);
    for (int i = 0; i < 6 && i < ack_log.size(); i++) chk("t1_ack_addr", ack_log[i], 32'h100 + i);
    chk("t1_pop_count", pop_log.size(), 6);
    if (pop_log.size() == 6) begin
      chk("t1_byte0", int'(pop_log[0]), 32'hA4);
      chk("t1_byte1", int'(pop_log[1]), 32'hA5);
      chk("t1_byte2", int'(pop_log[2]), 32'hA6);
      chk("t1_byte3", int'(pop_log[3]), 32'hA7);
      chk("t1_byte4", int'(pop_log[4]), 32'hA0);
      chk("t1_byte5", int'(pop_log[5]), 32'hA1);
    end
    chk("t1_done", int'(done), 1);
    chk("t1_req_low", int'(dif.dma_req), 0);

    // no pops, same-cycle acks: exactly DEPTH reads, then one more per pop
    ack_mode = 1; lat_min = 3; lat_max = 3; pop_pct = 0;
    start_range(32'h200, 32'h2FF, 0);
    run(30);
    chk("t2_ack_count", ack_log.size(), 8);
    chk("t2_req_low", int'(dif.dma_req), 0);
    chk("t2_model_full", m_fifo.size(), 8);
    pop_pct = 100;
    cycle();
    pop_pct = 0;
    run(20);
    chk("t2_ack_after_pop", ack_log.size(), 9);
    chk("t2_popped_byte", pop_log.size() == 1 ? int'(pop_log[0]) : -1, 32'hA7);

    // looping range wrapping through address zero
    ack_mode = 1; lat_min = 1; lat_max = 1; pop_pct = 100;
    start_range(32'h1FFFFE, 32'h000001, 1);
    run(20);
    chk("t3_seq_len", int'(ack_log.size() >= 5), 1);
    if (ack_log.size() >= 5) begin
      chk("t3_addr0", ack_log[0], 32'h1FFFFE);
      chk("t3_addr1", ack_log[1], 32'h1FFFFF);
      chk("t3_addr2", ack_log[2], 32'h000000);
      chk("t3_addr3", ack_log[3], 32'h000001);
      chk("t3_addr4", ack_log[4], 32'h1FFFFE);
    end
    chk("t3_done_low", int'(done), 0);

    // init with two reads in flight and a request pending
    ack_mode = 1; lat_min = 6; lat_max = 6; pop_pct = 100;
    start_range(32'h300, 32'h3FF, 0);
    guard = 0;
    hit = 1'b0;
    while (!hit && guard < 40) begin
      cycle();
      guard++;
      hit = (m_pend == 2) && (m_req == 1);
    end
    chk("t4_pend2_reached", int'(hit), 1);
    ack_mode = 0;
    start_range(32'h350, 32'h3FF, 0);
    cycle();
    chk("t4_model_drop", m_drop, 2);
    ack_mode = 1;
    cycle();
    chk("t4_req_dropped", int'(dif.dma_req), 0);
    run(25);
    chk("t4_resume_addr", ack_log.size() != 0 ? ack_log[0] : -1, 32'h350);

    // fill, then pop at full, then drain past empty
    ack_mode = 1; lat_min = 2; lat_max = 2; pop_pct = 0;
    start_range(32'h400, 32'h4FF, 0);
    run(25);
    pop_pct = 100;
    run(30);
    chk("t5_first_pop", pop_log.size() >= 2 ? int'(pop_log[0]) : -1, 32'hA1);
    chk("t5_second_pop", pop_log.size() >= 2 ? int'(pop_log[1]) : -1, 32'hA0);
    k_ena = 0;
    run(15);
    chk("t5_drained", int'(rd_valid), 0);

    // ena removed while a request waits for its ack
    k_ena = 1; ack_mode = 0; pop_pct = 100;
    start_range(32'h500, 32'h5FF, 0);
    run(3);
    chk("t6_req_up", int'(dif.dma_req), 1);
    k_ena = 0;
    run(3);
    chk("t6_req_held", int'(dif.dma_req), 1);
    chk("t6_addr_held", int'(dif.dma_addr), 32'h500);
    ack_mode = 1;
    run(2);
    chk("t6_req_released", int'(dif.dma_req), 0);
    chk("t6_addr_next", int'(dif.dma_addr), 32'h501);

    // reset in the middle of traffic
    k_ena = 1; ack_mode = 3; ack_pct = 70; lat_min = 1; lat_max = 4; pop_pct = 50;
    start_range(32'h600, 32'h6FF, 0);
    run(20);
    do_reset();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99) < 3) begin
        int s;
        s = ($urandom_range(3) == 0) ? (32'h1FFFF0 + int'($urandom_range(15)))
                                     : int'($urandom & AMASK);
        start_range(s, (s + int'($urandom_range(20))) & AMASK, int'($urandom_range(1)));
      end
      if ($urandom_range(99) < 5) k_ena = ($urandom_range(9) != 0);
      if ($urandom_range(99) < 5) ack_pct = int'($urandom_range(100, 30));
      if ($urandom_range(99) < 5) pop_pct = int'($urandom_range(100));
      lat_min = 1; lat_max = 4;
      if (i == 750) do_reset();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dma_fifo_reader.md
Name: dma_fifo_reader

Overview:
- Read-only DMA end-user client that plugs into one request slot (reqN/ackN/endN/rnwN/addrN/wdN) of the DMA sequencer.
- Fetches bytes from sequential memory addresses into a small first-word-fall-through FIFO for a streaming consumer, such as a sound channel or an SD/MP3 data pump.
- Supports one-shot and looping address ranges.
- Tracks in-flight reads so the FIFO can never overflow.

Parameters:
- DEPTH_LOG, 3, log2 of FIFO depth (DEPTH = 2**DEPTH_LOG bytes).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- init  input  1  one-cycle pulse: load start address, flush FIFO, clear done, drain in-flight reads
- ena  input  1  level: allow new DMA requests
- loop  input  1  level: at end_addr wrap to start_addr instead of stopping
- start_addr  input  21  first byte address, sampled on init and on loop wrap
- end_addr  input  21  last byte address of range, inclusive
- dma_req  output  1  request to sequencer slot, registered
- dma_addr  output  21  read address, registered
- dma_rnw  output  1  constant 1
- dma_wd  output  8  constant 8'h00
- dma_ack  input  1  slot ack: current address accepted
- dma_end  input  1  slot end: dma_rd valid this cycle
- dma_rd  input  8  read data from sequencer
- rd_pop  input  1  consumer pops the head byte
- rd_data  output  8  FIFO head byte, valid while rd_valid=1
- rd_valid  output  1  FIFO not empty
- done  output  1  non-loop range fully requested

Behaviour:
Reset values:
- dma_req=0, dma_addr=0, dma_rnw=1, dma_wd=0, rd_valid=0, done=0.
- Internal FIFO count, pointers, pend and drop all 0.

Internal counters:
- count: FIFO occupancy, 0..DEPTH.
- pend: acked but not yet ended reads, 0..DEPTH.
- drop: ends still to discard after init.

Request rule (slot protocol):
- dma_req, once high, stays high until the cycle dma_ack=1. Address is stable throughout.
- Exception: init forces dma_req=0 on the next edge, even if no ack has come.
- Next-edge value: dma_req <= !init & (ack_this_cycle ? new_ok : (dma_req | new_ok)).
- new_ok = ena & !done & (drop_next==0) & (count_next + pend_next < DEPTH). Computed from post-edge values.
- Back-to-back acks are allowed when headroom exists. Multiple outstanding reads are tracked by pend.
- ena=0 while dma_req=1 does not withdraw the pending request. It only blocks new ones.

Address advance:
- Happens on an edge with dma_ack=1 and no init.
- If dma_addr==end_addr and loop=1: dma_addr<=start_addr.
- If dma_addr==end_addr and loop=0: done<=1, and no further requests.
- Otherwise: dma_addr<=dma_addr+1, modulo 2**21 (1FFFFF -> 000000).
- If start_addr>end_addr, the range wraps through 000000.

Completion:
- dma_end=1 and drop==0: push dma_rd into FIFO and pend--.
- dma_end=1 and drop!=0: discard the data, drop--, pend--.
- ack and end in the same cycle: pend unchanged.

FIFO:
- First-word fall-through. rd_data = mem[rptr].
- rd_pop with rd_valid=1: rptr++ and count--.
- rd_pop with rd_valid=0: ignored.
- Push and pop in the same cycle: count unchanged. This also works at count==DEPTH (pop frees) and count==0 (push then visible the next cycle).
- Push at full cannot occur by construction.

init (mid-operation):
- Next edge: dma_addr<=start_addr, FIFO pointers and count<=0, rd_valid<=0, done<=0.
- drop <= pend_next, i.e. in-flight reads, counting an ack arriving in the init cycle and minus an end arriving in it.
- New requests start only once drop==0 and ena=1.
- init with pend=0 and ena=1: dma_req rises on the 2nd edge after the init cycle.

Test Plan:
- Reset, init with start=0x00100, end=0x00105, loop=0, ena=1; ack each req 1 cycle after assertion and end 2 cycles after ack; pop continuously -> addresses 100..105 requested, 6 bytes out in order, done=1 after the 6th ack, dma_req stays 0 afterwards.
- DEPTH=8, no pops, same-cycle acks, ends 3 cycles later -> exactly 8 acks, then dma_req=0 with count=8; one pop -> exactly one further request issued.
- loop=1, start=0x1FFFFE, end=0x000001 -> address sequence 1FFFFE,1FFFFF,000000,000001,1FFFFE...; done stays 0.
- init pulsed while pend=2 and dma_req=1 -> dma_req=0 next cycle; next 2 dma_end bytes discarded (rd_valid stays 0); requests resume from start_addr after the 2nd end.
- Simultaneous push and pop at count=8 and at count=0 -> count 8 and 1 respectively, data order preserved; pop on empty leaves state unchanged.
- ena dropped while dma_req=1 unacked -> req held until ack, then 0; rst_n asserted mid-transfer -> all outputs return to reset values immediately.
